// File: rtl/mem_ctrl_arb.sv
// -----------------------------------------------------------------------------
// mem_ctrl_arb
//
// Arbitrates up to four requester channels onto a single byte-wide RAM port.
// A granted request (read or write of 1/2/4/8 bytes, clipped to DATA_W/8) is
// serialised into one byte access per cycle. Read bytes are assembled
// little-endian and presented as a zero-extended word with a one-cycle
// completion pulse. Reads may be aborted by the owning port via cancel_i.
//
// Build option:
//   ARB_ROUND_ROBIN_EN  defined   -> round-robin grant, search starts after the
//                                    last-granted port (pointer reset to 0)
//                       undefined -> fixed priority, lowest index wins
//
// Ports:
//   clk, rst (sync, active high), rdy (global enable, low freezes everything)
//   req_valid_i/req_wr_i/req_addr_i/req_size_i/req_wdata_i  per-port request
//   cancel_i      per-port abort of an in-flight read
//   req_ack_o     one-cycle acceptance pulse (cycle after the grant edge)
//   resp_valid_o  one-cycle completion pulse, resp_port_o = completing port
//   resp_data_o   last completed read data, held until the next read completes
//   ram_din_i     RAM read byte for the address currently driven
//   ram_dout_o, ram_addr_o, ram_wr_o   RAM byte port (all zero outside XFER)
//   busy_o        high while not IDLE
// -----------------------------------------------------------------------------
module mem_ctrl_arb #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rdy,
    input  logic [NUM_PORTS-1:0]        req_valid_i,
    input  logic [NUM_PORTS-1:0]        req_wr_i,
    input  logic [NUM_PORTS*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_PORTS*2-1:0]      req_size_i,
    input  logic [NUM_PORTS*DATA_W-1:0] req_wdata_i,
    input  logic [NUM_PORTS-1:0]        cancel_i,
    output logic [NUM_PORTS-1:0]        req_ack_o,
    output logic                        resp_valid_o,
    output logic [1:0]                  resp_port_o,
    output logic [DATA_W-1:0]           resp_data_o,
    input  logic [7:0]                  ram_din_i,
    output logic [7:0]                  ram_dout_o,
    output logic [ADDR_W-1:0]           ram_addr_o,
    output logic                        ram_wr_o,
    output logic                        busy_o
);

    localparam int MAX_BYTES = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           port_q, port_d;
    logic                 wr_q, wr_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic [2:0]           cnt_q, cnt_d;
    logic [2:0]           last_q, last_d;
    logic [DATA_W-1:0]    rbuf_q, rbuf_d;
    logic [DATA_W-1:0]    resp_data_q, resp_data_d;
    logic                 resp_valid_q, resp_valid_d;
    logic [1:0]           resp_port_q, resp_port_d;
    logic [NUM_PORTS-1:0] ack_q, ack_d;

    // Per-port vectors widened to four entries so a 2-bit port index always
    // selects in range whatever NUM_PORTS is.
    logic [3:0] valid_ext, wr_ext, cancel_ext;
    assign valid_ext  = 4'(req_valid_i);
    assign wr_ext     = 4'(req_wr_i);
    assign cancel_ext = 4'(cancel_i);

    logic [1:0] grant;
    logic [1:0] grant_size;
    logic [3:0] grant_bytes;
    logic [2:0] grant_last;

`ifdef ARB_ROUND_ROBIN_EN
    logic [1:0] ptr_q, ptr_d;

    // Walk from farthest to nearest candidate after the pointer so the
    // nearest requesting port is the last assignment and wins.
    always_comb begin
        grant = ptr_q;
        for (int i = NUM_PORTS; i >= 1; i--) begin
            if (valid_ext[2'((int'(ptr_q) + i) % NUM_PORTS)]) begin
                grant = 2'((int'(ptr_q) + i) % NUM_PORTS);
            end
        end
    end
`else
    always_comb begin
        grant = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (valid_ext[2'(i)]) begin
                grant = 2'(i);
            end
        end
    end
`endif

    // Byte count of the granted request minus one, clipped to the data width.
    always_comb begin
        grant_size  = req_size_i[int'(grant)*2 +: 2];
        grant_bytes = 4'd1 << grant_size;
        if (int'(grant_bytes) > MAX_BYTES) begin
            grant_last = 3'(MAX_BYTES - 1);
        end else begin
            grant_last = 3'(grant_bytes - 4'd1);
        end
    end

    always_comb begin
        state_d      = state_q;
        port_d       = port_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        last_d       = last_q;
        rbuf_d       = rbuf_q;
        resp_data_d  = resp_data_q;
        resp_port_d  = resp_port_q;
        resp_valid_d = 1'b0;
        ack_d        = '0;
`ifdef ARB_ROUND_ROBIN_EN
        ptr_d        = ptr_q;
`endif
        case (state_q)
            // GAP's exit edge also arbitrates, so a waiting request can be
            // accepted one cycle after completion instead of two.
            IDLE, GAP: begin
                state_d = IDLE;
                if (|req_valid_i) begin
                    state_d = XFER;
                    port_d  = grant;
                    wr_d    = wr_ext[grant];
                    addr_d  = req_addr_i[int'(grant)*ADDR_W +: ADDR_W];
                    wdata_d = req_wdata_i[int'(grant)*DATA_W +: DATA_W];
                    cnt_d   = '0;
                    last_d  = grant_last;
                    rbuf_d  = '0;
                    for (int i = 0; i < NUM_PORTS; i++) begin
                        ack_d[i] = (grant == 2'(i));
                    end
`ifdef ARB_ROUND_ROBIN_EN
                    ptr_d   = grant;
`endif
                end
            end
            XFER: begin
                if (!wr_q && cancel_ext[port_q]) begin
                    state_d = GAP;
                end else begin
                    if (!wr_q) begin
                        rbuf_d[int'(cnt_q)*8 +: 8] = ram_din_i;
                    end
                    if (cnt_q == last_q) begin
                        state_d      = GAP;
                        resp_valid_d = 1'b1;
                        resp_port_d  = port_q;
                        if (!wr_q) begin
                            resp_data_d = rbuf_d;
                        end
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            port_q       <= '0;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            last_q       <= '0;
            rbuf_q       <= '0;
            resp_data_q  <= '0;
            resp_port_q  <= '0;
            resp_valid_q <= 1'b0;
            ack_q        <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            ptr_q        <= '0;
`endif
        end else if (rdy) begin
            state_q      <= state_d;
            port_q       <= port_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            last_q       <= last_d;
            rbuf_q       <= rbuf_d;
            resp_data_q  <= resp_data_d;
            resp_port_q  <= resp_port_d;
            resp_valid_q <= resp_valid_d;
            ack_q        <= ack_d;
`ifdef ARB_ROUND_ROBIN_EN
            ptr_q        <= ptr_d;
`endif
        end
    end

    assign req_ack_o    = ack_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_port_o  = resp_port_q;
    assign resp_data_o  = resp_data_q;
    assign busy_o       = (state_q != IDLE);
    assign ram_addr_o   = (state_q == XFER) ? addr_q + ADDR_W'(cnt_q) : '0;
    assign ram_wr_o     = (state_q == XFER) && wr_q;
    assign ram_dout_o   = (state_q == XFER) ? wdata_q[int'(cnt_q)*8 +: 8] : 8'd0;

endmodule

// File: tb/tb_mem_ctrl_arb.sv
// -----------------------------------------------------------------------------
// tb_mem_ctrl_arb
//
// Directed bench for mem_ctrl_arb (default 2 ports, 32-bit address and data).
// A byte RAM model answers the RAM port combinationally. A transaction-level
// model turns each accepted request into a timeline of expected per-cycle
// outputs; one process compares every DUT output against it each cycle, and
// directed scenarios pin the model with hand-computed literals.
// -----------------------------------------------------------------------------
module tb_mem_ctrl_arb;

    localparam int NP = 2;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk;
    logic            rst;
    logic            rdy;
    logic [NP-1:0]   req_valid_i;
    logic [NP-1:0]   req_wr_i;
    logic [NP*AW-1:0] req_addr_i;
    logic [NP*2-1:0] req_size_i;
    logic [NP*DW-1:0] req_wdata_i;
    logic [NP-1:0]   cancel_i;
    logic [NP-1:0]   req_ack_o;
    logic            resp_valid_o;
    logic [1:0]      resp_port_o;
    logic [DW-1:0]   resp_data_o;
    logic [7:0]      ram_din_i;
    logic [7:0]      ram_dout_o;
    logic [AW-1:0]   ram_addr_o;
    logic            ram_wr_o;
    logic            busy_o;

    mem_ctrl_arb #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .req_valid_i  (req_valid_i),
        .req_wr_i     (req_wr_i),
        .req_addr_i   (req_addr_i),
        .req_size_i   (req_size_i),
        .req_wdata_i  (req_wdata_i),
        .cancel_i     (cancel_i),
        .req_ack_o    (req_ack_o),
        .resp_valid_o (resp_valid_o),
        .resp_port_o  (resp_port_o),
        .resp_data_o  (resp_data_o),
        .ram_din_i    (ram_din_i),
        .ram_dout_o   (ram_dout_o),
        .ram_addr_o   (ram_addr_o),
        .ram_wr_o     (ram_wr_o),
        .busy_o       (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- RAM model (4 KiB, address folded to 12 bits) ----------
    logic [7:0] mem [4096];
    assign ram_din_i = mem[ram_addr_o[11:0]];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 8'(i * 7 + 3);
            mem[12'h100] <= 8'h11;
            mem[12'h101] <= 8'h22;
            mem[12'h102] <= 8'h33;
            mem[12'h103] <= 8'h44;
        end else if (ram_wr_o) begin
            mem[ram_addr_o[11:0]] <= ram_dout_o;
        end
    end

    // ---------------- counters and check helper ------------------------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ------------------------------
    typedef struct packed {
        logic        busy;
        logic [1:0]  ack;
        logic [31:0] addr;
        logic        wr;
        logic [7:0]  dout;
        logic        rv;
        logic [1:0]  rport;
        logic        setd;
        logic [31:0] data;
        logic        is_read;
        logic [1:0]  port;
    } rec_t;

    rec_t        cur;      // expected outputs for the current cycle
    rec_t        tl[$];    // remaining timeline of the active request
    logic [31:0] m_data;
    int          m_ptr;
    int          cyc;

    function automatic int pick();
`ifdef ARB_ROUND_ROBIN_EN
        for (int off = 1; off <= NP; off++) begin
            int c = (m_ptr + off) % NP;
            if (req_valid_i[c]) return c;
        end
`else
        for (int i = 0; i < NP; i++) begin
            if (req_valid_i[i]) return i;
        end
`endif
        return 0;
    endfunction

    task automatic model_accept();
        int          g;
        int          nb;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        logic [31:0] ak;
        logic        w;
        rec_t        r;
        g  = pick();
        a  = req_addr_i[g*32 +: 32];
        wd = req_wdata_i[g*32 +: 32];
        w  = req_wr_i[g];
        nb = 1 << int'(req_size_i[g*2 +: 2]);
        if (nb > DW / 8) nb = DW / 8;
        rd = '0;
        for (int k = 0; k < nb; k++) begin
            ak        = a + 32'(k);
            r         = '0;
            r.busy    = 1'b1;
            r.ack     = (k == 0) ? 2'(1 << g) : 2'b00;
            r.addr    = ak;
            r.wr      = w;
            r.dout    = wd[8*k +: 8];
            r.is_read = !w;
            r.port    = 2'(g);
            tl.push_back(r);
            if (!w) rd[8*k +: 8] = mem[ak[11:0]];
        end
        r       = '0;
        r.busy  = 1'b1;
        r.rv    = 1'b1;
        r.rport = 2'(g);
        r.setd  = !w;
        r.data  = rd;
        tl.push_back(r);
        m_ptr = g;
        cur   = tl.pop_front();
    endtask

    task automatic model_step();
        if (rst) begin
            tl.delete();
            cur    = '0;
            m_data = '0;
            m_ptr  = 0;
        end else if (rdy) begin
            if (tl.size() == 0) begin
                if (req_valid_i != '0) model_accept();
                else cur = '0;
            end else if (cur.is_read && (((cancel_i >> cur.port) & 2'b01) != 2'b00)) begin
                tl.delete();
                cur      = '0;
                cur.busy = 1'b1;
            end else begin
                cur = tl.pop_front();
            end
            if (cur.setd) m_data = cur.data;
        end
    endtask

    initial begin
        cur    = '0;
        m_data = '0;
        m_ptr  = 0;
        cyc    = 0;
        forever begin
            @(posedge clk);
            cyc++;
            model_step();
        end
    end

    // ---------------- per-cycle compare + event logs ---------------------
    bit        chk_en = 0;
    int        resp_cnt = 0;
    int        ack_cyc = 0;
    int        resp_cyc = 0;
    int        last_port = 0;
    int        grant_log[$];
    logic [NP-1:0] prev_ack = '0;
    logic      prev_rv = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("busy",       64'(busy_o),       64'(cur.busy));
                chk("ack",        64'(req_ack_o),    64'(cur.ack));
                chk("resp_valid", 64'(resp_valid_o), 64'(cur.rv));
                if (cur.rv) chk("resp_port", 64'(resp_port_o), 64'(cur.rport));
                chk("resp_data",  64'(resp_data_o),  64'(m_data));
                chk("ram_addr",   64'(ram_addr_o),   64'(cur.addr));
                chk("ram_wr",     64'(ram_wr_o),     64'(cur.wr));
                chk("ram_dout",   64'(ram_dout_o),   64'(cur.dout));
            end
            if (req_ack_o != '0 && prev_ack == '0) begin
                ack_cyc = cyc;
                grant_log.push_back(req_ack_o[1] ? 1 : 0);
                $display("ack   cyc=%0d port=%0d", cyc, req_ack_o[1] ? 1 : 0);
            end
            if (resp_valid_o && !prev_rv) begin
                resp_cnt++;
                resp_cyc  = cyc;
                last_port = int'(resp_port_o);
                $display("resp  cyc=%0d port=%0d data=%08h", cyc, resp_port_o, resp_data_o);
            end
            prev_ack = req_ack_o;
            prev_rv  = resp_valid_o;
        end
    end

    // ---------------- stimulus helpers ------------------------------------
    task automatic issue(input int p, input bit w, input int sz,
                         input logic [31:0] a, input logic [31:0] wd);
        bit got = 0;
        req_wr_i[p]              = w;
        req_size_i[p*2 +: 2]     = 2'(sz);
        req_addr_i[p*32 +: 32]   = a;
        req_wdata_i[p*32 +: 32]  = wd;
        req_valid_i[p]           = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #1;
            if (req_ack_o[p]) got = 1;
        end
        req_valid_i[p] = 1'b0;
        chk("ack_seen", 64'(got), 64'd1);
    endtask

    task automatic wait_idle();
        bit got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk); #1;
            if (!busy_o) got = 1;
        end
        chk("idle_reached", 64'(got), 64'd1);
    endtask

    // ---------------- directed scenarios ----------------------------------
    int exp_g[4];
    int rc;

    initial begin
        rst         = 1'b1;
        rdy         = 1'b1;
        req_valid_i = '0;
        req_wr_i    = '0;
        req_addr_i  = '0;
        req_size_i  = '0;
        req_wdata_i = '0;
        cancel_i    = '0;
        @(posedge clk); #1;
        chk_en = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_data", 64'(resp_data_o), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 4-byte read at 0x100 from port 0
        issue(0, 1'b0, 2, 32'h100, 32'h0);
        wait_idle();
        chk("rd4_data", 64'(resp_data_o), 64'h44332211);
        chk("rd4_port", 64'(last_port), 64'd0);
        chk("rd4_lat",  64'(resp_cyc - ack_cyc), 64'd4);

        // 2-byte write from port 1 to 0x30000 (folds to RAM index 0)
        issue(1, 1'b1, 1, 32'h30000, 32'h0000BEEF);
        wait_idle();
        chk("wr2_b0",   64'(mem[12'h000]), 64'hEF);
        chk("wr2_b1",   64'(mem[12'h001]), 64'hBE);
        chk("wr2_hold", 64'(resp_data_o), 64'h44332211);
        chk("wr2_port", 64'(last_port), 64'd1);

        // size 3 clipped to 4 bytes; single byte read
        issue(1, 1'b0, 3, 32'h100, 32'h0);
        wait_idle();
        chk("clip_data", 64'(resp_data_o), 64'h44332211);
        chk("clip_lat",  64'(resp_cyc - ack_cyc), 64'd4);
        issue(0, 1'b0, 0, 32'h102, 32'h0);
        wait_idle();
        chk("rd1_data", 64'(resp_data_o), 64'h00000033);
        chk("rd1_lat",  64'(resp_cyc - ack_cyc), 64'd1);

        // address wraps from 0xFFFFFFFF to 0
        issue(0, 1'b0, 1, 32'hFFFF_FFFF, 32'h0);
        wait_idle();
        chk("wrap_data", 64'(resp_data_o), 64'h0000EFFC);

        // both ports request continuously
`ifdef ARB_ROUND_ROBIN_EN
        exp_g = '{1, 0, 1, 0};
`else
        exp_g = '{0, 0, 0, 0};
`endif
        grant_log.delete();
        req_wr_i                = 2'b00;
        req_size_i              = 4'b0000;
        req_addr_i[31:0]        = 32'h100;
        req_addr_i[63:32]       = 32'h101;
        req_valid_i             = 2'b11;
        for (int i = 0; i < 60 && grant_log.size() < 4; i++) begin
            @(posedge clk); #1;
        end
        req_valid_i = 2'b00;
        wait_idle();
        chk("arb_ngrants", 64'(grant_log.size()), 64'd4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++) begin
            chk($sformatf("arb_grant%0d", i), 64'(grant_log[i]), 64'(exp_g[i]));
        end

        // cancel of a read at E0+2
        rc = resp_cnt;
        issue(0, 1'b0, 2, 32'h100, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        cancel_i[0] = 1'b1;
        @(posedge clk); #1;
        cancel_i[0] = 1'b0;
        @(posedge clk); #1;
        chk("cancel_idle",  64'(busy_o), 64'd0);
        chk("cancel_nresp", 64'(resp_cnt), 64'(rc));
        issue(1, 1'b0, 0, 32'h103, 32'h0);
        wait_idle();
        chk("after_cancel_data", 64'(resp_data_o), 64'h00000044);

        // cancel ignored for writes and for other ports
        cancel_i = 2'b11;
        issue(0, 1'b1, 1, 32'h40, 32'h00001234);
        wait_idle();
        cancel_i = 2'b00;
        chk("cwr_b0", 64'(mem[12'h040]), 64'h34);
        chk("cwr_b1", 64'(mem[12'h041]), 64'h12);
        cancel_i = 2'b10;
        issue(0, 1'b0, 1, 32'h100, 32'h0);
        wait_idle();
        cancel_i = 2'b00;
        chk("cother_data", 64'(resp_data_o), 64'h00002211);

        // rdy low for 3 cycles during byte 1
        issue(0, 1'b0, 2, 32'h100, 32'h0);
        @(posedge clk); #1;
        rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rdy = 1'b1;
        wait_idle();
        chk("stall_data", 64'(resp_data_o), 64'h44332211);
        chk("stall_lat",  64'(resp_cyc - ack_cyc), 64'd7);

        // reset in the middle of a repeat transfer
        rc = resp_cnt;
        issue(0, 1'b0, 2, 32'h100, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rstx_busy", 64'(busy_o), 64'd0);
        chk("rstx_data", 64'(resp_data_o), 64'd0);
        chk("rstx_addr", 64'(ram_addr_o), 64'd0);
        chk("rstx_wr",   64'(ram_wr_o), 64'd0);
        chk("rstx_ack",  64'(req_ack_o), 64'd0);
        repeat (6) @(posedge clk);
        #1;
        chk("rstx_nresp", 64'(resp_cnt), 64'(rc));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
